// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state type and divisor limits for the programmable clock divider
package clk_div_pkg;
  typedef enum logic {IDLE, RUN} clk_div_state_t;
  localparam int DIV_MIN = 2;
endpackage

// File: rtl/clk_div_duty_out.sv
// clk_div_duty_out: dual-edge output stage producing a 50% duty clock for odd and even divisors
module clk_div_duty_out (
  input  logic clk,
  input  logic rst,
  input  logic pos_d,
  input  logic odd,
  output logic clk_out
);
  logic pos_q;
  logic neg_q;
  // posedge phase flop, high for the first H cycles of each period
  always_ff @(posedge clk) pos_q <= rst ? 1'b0 : pos_d;
  // half-cycle delayed copy; no reset needed because pos_q gates it low
  always_ff @(negedge clk) neg_q <= pos_q;
  assign clk_out = odd ? (pos_q & neg_q) : pos_q;
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with boundary-synchronous divisor change
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  output logic             div_err,
  output logic             div_pend,
  output logic [DIV_W-1:0] div_cur,
  output logic             tick,
  output logic             clk_out
);
  clk_div_state_t state, state_next;
  logic [DIV_W-1:0] cnt, cnt_next, pend_val, div_cur_next;
  logic [DIV_W:0]   h;
  logic             wrap, xfer, load_ok, pos_d;
  // next-state, counter, divisor transfer and phase decode
  always_comb begin
    state_next   = en ? RUN : IDLE;
    wrap         = (state == RUN) && (cnt == div_cur - 1'b1);
    cnt_next     = (state == RUN && en && !wrap) ? cnt + 1'b1 : '0;
    xfer         = div_pend && en && (state == IDLE || wrap);
    div_cur_next = xfer ? pend_val : div_cur;
    load_ok      = div_load && (div_in >= DIV_W'(DIV_MIN));
    h            = ({1'b0, div_cur_next} + (DIV_W+1)'(1)) >> 1;
    pos_d        = (state_next == RUN) && ({1'b0, cnt_next} < h);
  end
  // state, counter, divisor and pending-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cur  <= DIV_W'(DEF_DIV);
      pend_val <= DIV_W'(DEF_DIV);
      div_pend <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      div_cur  <= div_cur_next;
      pend_val <= load_ok ? div_in : pend_val;
      div_pend <= load_ok ? 1'b1 : (xfer ? 1'b0 : div_pend);
      div_err  <= div_load && !load_ok;
    end
  end
  assign tick = (state == RUN) && (cnt == '0);
  clk_div_duty_out u_duty (
    .clk    (clk),
    .rst    (rst),
    .pos_d  (pos_d),
    .odd    (div_cur[0]),
    .clk_out(clk_out)
  );
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for the programmable clock divider
module tb_clk_div_prog;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       div_err, div_pend, tick, clk_out;
  logic [7:0] div_cur;
  int total = 0;
  int bad = 0;

  clk_div_prog dut (
    .clk(clk), .rst(rst), .en(en), .div_load(div_load), .div_in(div_in),
    .div_err(div_err), .div_pend(div_pend), .div_cur(div_cur), .tick(tick), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // counts high half-cycle samples of clk_out and ticks over n clk cycles
  task automatic meas(input int n, output int hi, output int ticks);
    hi = 0;
    ticks = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      hi += int'(clk_out);
      ticks += int'(tick);
      @(negedge clk);
      #1;
      hi += int'(clk_out);
    end
  endtask

  task automatic load_and_wait(input logic [7:0] v, input string name);
    div_in = v;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    for (int i = 0; i < 300 && div_pend; i++) step();
    total++;
    if (div_pend !== 1'b0 || div_cur !== v) begin
      bad++;
      $display("FAIL %s transfer: div_pend=%0b div_cur=%0d want pend=0 cur=%0d", name, div_pend, div_cur, v);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if ({clk_out, tick, div_pend, div_err} !== 4'b0000 || div_cur !== 8'd7) begin
      bad++;
      $display("FAIL reset: out=%0b tick=%0b pend=%0b err=%0b cur=%0d want 0 0 0 0 7", clk_out, tick, div_pend, div_err, div_cur);
    end
    rst = 1'b0;
    step();
    total++;
    if (tick !== 1'b0 || clk_out !== 1'b0) begin
      bad++;
      $display("FAIL idle: tick=%0b out=%0b want 0 0", tick, clk_out);
    end
  endtask

  task automatic test_default();
    int hi, t;
    en = 1'b1;
    step();
    total++;
    if (tick !== 1'b1 || clk_out !== 1'b0 || div_cur !== 8'd7 || div_pend !== 1'b0) begin
      bad++;
      $display("FAIL start7: tick=%0b out=%0b cur=%0d pend=%0b want 1 0 7 0", tick, clk_out, div_cur, div_pend);
    end
    @(negedge clk);
    #1;
    total++;
    if (clk_out !== 1'b1) begin
      bad++;
      $display("FAIL rise7: out=%0b want 1", clk_out);
    end
    meas(70, hi, t);
    total++;
    if (hi !== 70 || t !== 10) begin
      bad++;
      $display("FAIL duty7: hi=%0d ticks=%0d want 70 10", hi, t);
    end
  endtask

  task automatic test_load();
    int hi, t;
    repeat (3) step();
    div_in = 8'd4;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    total++;
    if (div_pend !== 1'b1 || div_cur !== 8'd7) begin
      bad++;
      $display("FAIL pend4: pend=%0b cur=%0d want 1 7", div_pend, div_cur);
    end
    repeat (2) step();
    total++;
    if (div_pend !== 1'b1 || div_cur !== 8'd7 || tick !== 1'b0) begin
      bad++;
      $display("FAIL hold7: pend=%0b cur=%0d tick=%0b want 1 7 0", div_pend, div_cur, tick);
    end
    step();
    total++;
    if (div_pend !== 1'b0 || div_cur !== 8'd4 || tick !== 1'b1) begin
      bad++;
      $display("FAIL wrap4: pend=%0b cur=%0d tick=%0b want 0 4 1", div_pend, div_cur, tick);
    end
    meas(40, hi, t);
    total++;
    if (hi !== 40 || t !== 10) begin
      bad++;
      $display("FAIL duty4: hi=%0d ticks=%0d want 40 10", hi, t);
    end
  endtask

  task automatic test_err();
    int hi, t;
    logic [7:0] bad_vals [2] = '{8'd1, 8'd0};
    for (int k = 0; k < 2; k++) begin
      div_in = bad_vals[k];
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      total++;
      if (div_err !== 1'b1 || div_pend !== 1'b0 || div_cur !== 8'd4) begin
        bad++;
        $display("FAIL err%0d: err=%0b pend=%0b cur=%0d want 1 0 4", k, div_err, div_pend, div_cur);
      end
      step();
      total++;
      if (div_err !== 1'b0) begin
        bad++;
        $display("FAIL errpulse%0d: err=%0b want 0", k, div_err);
      end
    end
    meas(8, hi, t);
    total++;
    if (hi !== 8 || t !== 2) begin
      bad++;
      $display("FAIL errrun: hi=%0d ticks=%0d want 8 2", hi, t);
    end
  endtask

  task automatic test_range();
    int hi, t;
    load_and_wait(8'd2, "div2");
    meas(10, hi, t);
    total++;
    if (hi !== 10 || t !== 5) begin
      bad++;
      $display("FAIL duty2: hi=%0d ticks=%0d want 10 5", hi, t);
    end
    load_and_wait(8'd255, "div255");
    meas(510, hi, t);
    total++;
    if (hi !== 510 || t !== 2) begin
      bad++;
      $display("FAIL duty255: hi=%0d ticks=%0d want 510 2", hi, t);
    end
  endtask

  task automatic test_enable();
    int hi, t;
    load_and_wait(8'd5, "div5");
    repeat (2) step();
    total++;
    if (clk_out !== 1'b1) begin
      bad++;
      $display("FAIL high5: out=%0b want 1", clk_out);
    end
    en = 1'b0;
    step();
    total++;
    if (clk_out !== 1'b0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL disable: out=%0b tick=%0b want 0 0", clk_out, tick);
    end
    meas(10, hi, t);
    total++;
    if (hi !== 0 || t !== 0) begin
      bad++;
      $display("FAIL parked: hi=%0d ticks=%0d want 0 0", hi, t);
    end
    en = 1'b1;
    step();
    total++;
    if (tick !== 1'b1 || clk_out !== 1'b0) begin
      bad++;
      $display("FAIL restart: tick=%0b out=%0b want 1 0", tick, clk_out);
    end
    @(negedge clk);
    #1;
    meas(5, hi, t);
    total++;
    if (hi !== 5 || t !== 1) begin
      bad++;
      $display("FAIL duty5: hi=%0d ticks=%0d want 5 1", hi, t);
    end
  endtask

  task automatic test_mid_reset();
    div_in = 8'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    total++;
    if (clk_out !== 1'b1 || div_pend !== 1'b1) begin
      bad++;
      $display("FAIL prerst: out=%0b pend=%0b want 1 1", clk_out, div_pend);
    end
    rst = 1'b1;
    step();
    total++;
    if (clk_out !== 1'b0 || div_cur !== 8'd7 || div_pend !== 1'b0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL midrst: out=%0b cur=%0d pend=%0b tick=%0b want 0 7 0 0", clk_out, div_cur, div_pend, tick);
    end
    @(negedge clk);
    #1;
    total++;
    if (clk_out !== 1'b0) begin
      bad++;
      $display("FAIL rstneg: out=%0b want 0", clk_out);
    end
    rst = 1'b0;
    step();
    total++;
    if (tick !== 1'b1 || div_cur !== 8'd7) begin
      bad++;
      $display("FAIL rstrun: tick=%0b cur=%0d want 1 7", tick, div_cur);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load();
    test_err();
    test_range();
    test_enable();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
